fetch_prefetch_queue: RTL and testbench

- Clocked, parametrised successor of the event-driven fetch stage.
- Generates sequential instruction addresses and requests words from instruction ROM over a req/ack handshake.
- Buffers fetched words with their PCs in a DEPTH-entry FIFO and presents them to decode over a valid/ready handshake.
- Supports PC redirect (branch) with queue flush and safe discard of an in-flight ROM response.

---
 rtl/fetch_prefetch_queue_if.sv | 31 +++
 rtl/fetch_prefetch_queue.sv | 136 +++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_queue_if.sv
// Bundles the ROM request, redirect and decode-side handshakes of the prefetch queue.
// The master modport is the fetch unit; the slave modport is the ROM/decode environment.
interface fetch_prefetch_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_pc;
  logic              out_ready;
  logic [CNT_W-1:0]  count;

  modport master (
    input  redirect_valid, redirect_pc, mem_ack, mem_data, out_ready,
    output mem_req, mem_addr, out_valid, out_data, out_pc, count
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_ack, mem_data, out_ready,
    input  mem_req, mem_addr, out_valid, out_data, out_pc, count
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Clocked fetch stage: sequential PC generation, single-outstanding ROM reads,
// and a DEPTH-entry FIFO of {word, pc} feeding decode, with redirect/flush support.
module fetch_prefetch_queue #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter int                 PC_STEP  = 1,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  fetch_prefetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic {
    ST_FETCH,
    ST_DRAIN
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] w_next_pc;
  logic              r_mem_req;
  logic              w_next_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] w_next_addr;
  logic              w_ack;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [ADDR_W-1:0] r_pcq  [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.out_valid = (r_count != '0);
  assign bus.out_data  = r_data[r_rptr];
  assign bus.out_pc    = r_pcq[r_rptr];
  assign bus.count     = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_FETCH;
      r_fetch_pc <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
    end else begin
      r_state    <= w_next_state;
      r_fetch_pc <= w_next_pc;
      r_mem_req  <= w_next_req;
      r_mem_addr <= w_next_addr;
    end
  end

  // An ack only counts while a request is outstanding; a redirect suppresses both
  // the push of a same-cycle response and any pop, and never launches a request.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_fetch_pc;
    w_next_req   = r_mem_req;
    w_next_addr  = r_mem_addr;
    w_push       = 1'b0;
    w_flush      = bus.redirect_valid;
    w_ack        = bus.mem_ack && r_mem_req;
    w_pop        = bus.out_ready && (r_count != '0) && !bus.redirect_valid;
    case (r_state)
      ST_FETCH: begin
        if (bus.redirect_valid) begin
          w_next_pc = bus.redirect_pc;
          if (r_mem_req && !bus.mem_ack) begin
            w_next_state = ST_DRAIN;
          end else begin
            w_next_req = 1'b0;
          end
        end else if (w_ack) begin
          w_push     = 1'b1;
          w_next_pc  = r_fetch_pc + ADDR_W'(PC_STEP);
          w_next_req = 1'b0;
        end else if (!r_mem_req && (r_count < CNT_W'(DEPTH))) begin
          w_next_req  = 1'b1;
          w_next_addr = r_fetch_pc;
        end
      end
      ST_DRAIN: begin
        if (bus.redirect_valid) begin
          w_next_pc = bus.redirect_pc;
        end
        if (w_ack) begin
          w_next_state = ST_FETCH;
          w_next_req   = 1'b0;
        end
      end
      default: begin
        w_next_state = ST_FETCH;
        w_next_req   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_pcq[i]  <= '0;
      end
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_data[r_wptr] <= bus.mem_data;
        r_pcq[r_wptr]  <= r_mem_addr;
        r_wptr         <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed testbench for fetch_prefetch_queue: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_fetch_prefetch_queue;
  logic clk;
  logic reset;
  int   vecCount;
  int   missCount;
  int   romWait;

  fetch_prefetch_queue_if #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) bus ();

  fetch_prefetch_queue #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(4), .PC_STEP(1), .RESET_PC(32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ROM model: acks the lat-th cycle a request is visible, data = addr + 0x100
  task automatic romCycle(input int lat);
    bus.mem_ack = 1'b0;
    if (bus.mem_req) begin
      romWait++;
      if (romWait >= lat) begin
        bus.mem_ack  = 1'b1;
        bus.mem_data = bus.mem_addr + 32'h100;
        romWait      = 0;
      end
    end else begin
      romWait = 0;
    end
  endtask

  task automatic applyReset();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.mem_ack        = 1'b0;
    bus.mem_data       = '0;
    bus.out_ready      = 1'b0;
    romWait            = 0;
    reset              = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.mem_ack        = 1'b0;
    bus.mem_data       = '0;
    bus.out_ready      = 1'b1;
    reset              = 1'b1;
    tick();
    tick();
    vecCount++;
    if (bus.mem_req !== 1'b0) begin
      missCount++; $display("[TB] FAIL reset_mem_req got %0b exp 0", bus.mem_req);
    end
    vecCount++;
    if (bus.mem_addr !== 32'h0) begin
      missCount++; $display("[TB] FAIL reset_mem_addr got %h exp 0", bus.mem_addr);
    end
    vecCount++;
    if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
      missCount++;
      $display("[TB] FAIL reset_fifo got valid=%0b count=%0d exp 0/0", bus.out_valid, bus.count);
    end
    vecCount++;
    if (bus.out_data !== 32'h0 || bus.out_pc !== 32'h0) begin
      missCount++;
      $display("[TB] FAIL reset_head got data=%h pc=%h exp 0/0", bus.out_data, bus.out_pc);
    end
    reset = 1'b0;
  endtask

  // Streams four words at a given ROM latency; also checks mem_addr stability
  task automatic test_sequential(input int lat);
    logic [31:0] expPc;
    logic        prevReq;
    logic        prevAck;
    logic [31:0] prevAddr;
    applyReset();
    bus.out_ready = 1'b1;
    expPc    = 0;
    prevReq  = 1'b0;
    prevAck  = 1'b0;
    prevAddr = '0;
    for (int c = 0; c < 60 && expPc < 4; c++) begin
      tick();
      if (prevReq && !prevAck) begin
        vecCount++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== prevAddr) begin
          missCount++;
          $display("[TB] FAIL seq_addr_hold got req=%0b addr=%h exp 1/%h",
                   bus.mem_req, bus.mem_addr, prevAddr);
        end
      end
      if (bus.out_valid === 1'b1) begin
        vecCount++;
        if (bus.out_pc !== expPc || bus.out_data !== expPc + 32'h100) begin
          missCount++;
          $display("[TB] FAIL seq_word got pc=%h data=%h exp %h/%h",
                   bus.out_pc, bus.out_data, expPc, expPc + 32'h100);
        end
        expPc++;
      end
      prevReq  = bus.mem_req;
      prevAddr = bus.mem_addr;
      romCycle(lat);
      prevAck = bus.mem_ack;
    end
    bus.mem_ack = 1'b0;
    vecCount++;
    if (expPc !== 32'd4) begin
      missCount++; $display("[TB] FAIL seq_words_seen got %0d exp 4", expPc);
    end
  endtask

  task automatic test_full_backpressure();
    applyReset();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      romCycle(1);
    end
    bus.mem_ack = 1'b0;
    vecCount++;
    if (bus.count !== 3'd4 || bus.mem_req !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL full_stall got count=%0d req=%0b exp 4/0", bus.count, bus.mem_req);
    end
    vecCount++;
    if (bus.out_pc !== 32'h0 || bus.out_data !== 32'h100) begin
      missCount++;
      $display("[TB] FAIL full_head got pc=%h data=%h exp 0/100", bus.out_pc, bus.out_data);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    vecCount++;
    if (bus.count !== 3'd3 || bus.out_pc !== 32'h1) begin
      missCount++;
      $display("[TB] FAIL full_pop got count=%0d pc=%h exp 3/1", bus.count, bus.out_pc);
    end
    tick();
    vecCount++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h4) begin
      missCount++;
      $display("[TB] FAIL full_rereq got req=%0b addr=%h exp 1/4", bus.mem_req, bus.mem_addr);
    end
  endtask

  task automatic test_redirect_drain();
    applyReset();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.mem_req === 1'b1) break;
    end
    vecCount++;
    if (bus.mem_req !== 1'b1) begin
      missCount++; $display("[TB] FAIL drain_first_req got %0b exp 1", bus.mem_req);
    end
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    tick();
    bus.redirect_valid = 1'b0;
    vecCount++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
      missCount++;
      $display("[TB] FAIL drain_hold got req=%0b addr=%h exp 1/0", bus.mem_req, bus.mem_addr);
    end
    tick();
    vecCount++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
      missCount++;
      $display("[TB] FAIL drain_hold2 got req=%0b addr=%h exp 1/0", bus.mem_req, bus.mem_addr);
    end
    tick();
    bus.mem_ack  = 1'b1;
    bus.mem_data = 32'h100;
    tick();
    bus.mem_ack = 1'b0;
    vecCount++;
    if (bus.mem_req !== 1'b0 || bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
      missCount++;
      $display("[TB] FAIL drain_discard got req=%0b valid=%0b count=%0d exp 0/0/0",
               bus.mem_req, bus.out_valid, bus.count);
    end
    tick();
    vecCount++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40) begin
      missCount++;
      $display("[TB] FAIL drain_target got req=%0b addr=%h exp 1/40", bus.mem_req, bus.mem_addr);
    end
    bus.mem_ack  = 1'b1;
    bus.mem_data = 32'h140;
    tick();
    bus.mem_ack = 1'b0;
    vecCount++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40 || bus.out_data !== 32'h140) begin
      missCount++;
      $display("[TB] FAIL drain_first_word got valid=%0b pc=%h data=%h exp 1/40/140",
               bus.out_valid, bus.out_pc, bus.out_data);
    end
  endtask

  task automatic test_redirect_ack_pop();
    applyReset();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.count === 3'd2) break;
      romCycle(1);
    end
    bus.mem_ack = 1'b0;
    vecCount++;
    if (bus.count !== 3'd2) begin
      missCount++; $display("[TB] FAIL rap_fill got count=%0d exp 2", bus.count);
    end
    tick();
    vecCount++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h2) begin
      missCount++;
      $display("[TB] FAIL rap_req got req=%0b addr=%h exp 1/2", bus.mem_req, bus.mem_addr);
    end
    bus.mem_ack        = 1'b1;
    bus.mem_data       = 32'h102;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    tick();
    bus.mem_ack        = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    vecCount++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL rap_flush got count=%0d valid=%0b req=%0b exp 0/0/0",
               bus.count, bus.out_valid, bus.mem_req);
    end
    tick();
    vecCount++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h80) begin
      missCount++;
      $display("[TB] FAIL rap_target got req=%0b addr=%h exp 1/80", bus.mem_req, bus.mem_addr);
    end
  endtask

  task automatic test_pc_wrap();
    applyReset();
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFF;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    vecCount++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'hFFFF_FFFF) begin
      missCount++;
      $display("[TB] FAIL wrap_req got req=%0b addr=%h exp 1/ffffffff", bus.mem_req, bus.mem_addr);
    end
    bus.mem_ack  = 1'b1;
    bus.mem_data = 32'h55;
    tick();
    bus.mem_ack = 1'b0;
    vecCount++;
    if (bus.out_pc !== 32'hFFFF_FFFF || bus.out_data !== 32'h55) begin
      missCount++;
      $display("[TB] FAIL wrap_word got pc=%h data=%h exp ffffffff/55", bus.out_pc, bus.out_data);
    end
    tick();
    vecCount++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
      missCount++;
      $display("[TB] FAIL wrap_next got req=%0b addr=%h exp 1/0", bus.mem_req, bus.mem_addr);
    end
  endtask

  task automatic test_reset_mid_transaction();
    applyReset();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.count === 3'd1 && bus.mem_req === 1'b1) break;
      romCycle(1);
    end
    bus.mem_ack = 1'b0;
    vecCount++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h1) begin
      missCount++;
      $display("[TB] FAIL rmid_setup got req=%0b addr=%h exp 1/1", bus.mem_req, bus.mem_addr);
    end
    reset = 1'b1;
    #1;
    vecCount++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.count !== 3'd0) begin
      missCount++;
      $display("[TB] FAIL rmid_async got req=%0b addr=%h count=%0d exp 0/0/0",
               bus.mem_req, bus.mem_addr, bus.count);
    end
    vecCount++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_pc !== 32'h0) begin
      missCount++;
      $display("[TB] FAIL rmid_head got valid=%0b data=%h pc=%h exp 0/0/0",
               bus.out_valid, bus.out_data, bus.out_pc);
    end
    tick();
    reset        = 1'b0;
    bus.mem_ack  = 1'b1;
    bus.mem_data = 32'hDEAD;
    tick();
    bus.mem_ack = 1'b0;
    vecCount++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL rmid_late_ack got count=%0d valid=%0b exp 0/0", bus.count, bus.out_valid);
    end
    vecCount++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
      missCount++;
      $display("[TB] FAIL rmid_restart got req=%0b addr=%h exp 1/0", bus.mem_req, bus.mem_addr);
    end
  endtask

  initial begin
    vecCount  = 0;
    missCount = 0;
    romWait   = 0;
    reset     = 1'b1;
    test_reset();
    test_sequential(1);
    test_sequential(3);
    test_full_backpressure();
    test_redirect_drain();
    test_redirect_ack_pop();
    test_pc_wrap();
    test_reset_mid_transaction();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
